id_issue_queue: RTL

//  Decode-side instruction buffer between fetch and the ID/EXE register; successor to the single-slot decode stage.
//  - Holds DEPTH fetched instructions and byte-swaps fetch words (big-endian) to internal order.
//  - Resolves operands from the register file or NFWD forwarding sources; stalls on load-use hazards.
//  - Issues one instruction per cycle into a registered valid/ready output stage.

---
 rtl/id_issue_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - decode-side issue queue: byte swap, operand forwarding, load-use stall, registered issue stage
// Optional feature macro: ID_PERF_CNT_EN adds saturating perf_stall/perf_issue counters.
module id_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int NFWD       = 2,
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             in_delay,
  input  logic             flush,
  output logic [31:0]      head_inst,
  input  logic             head_rreg1,
  input  logic             head_rreg2,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  input  logic [NFWD-1:0]  fwd_wreg,
  input  logic [NFWD-1:0]  fwd_mreg,
  input  logic [5*NFWD-1:0]  fwd_wa,
  input  logic [32*NFWD-1:0] fwd_wd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic             out_delay,
  output logic [31:0]      out_src1,
  output logic [31:0]      out_src2,
  output logic             stall_ld
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_issue
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [DEPTH-1:0] mem_delay;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, fire;
  logic [31:0]      in_swapped, head_pc;
  logic             head_delay;
  logic [31:0]      val1, val2, src1, src2;
  logic             ld1, ld2;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = ~full;
  assign push     = in_valid & ~full & ~flush;

  assign in_swapped = SWAP_BYTES ? {in_inst[7:0], in_inst[15:8], in_inst[23:16], in_inst[31:24]}
                                 : in_inst;

  assign head_inst  = empty ? 32'h0 : mem_inst[rd_ptr[AW-1:0]];
  assign head_pc    = mem_pc[rd_ptr[AW-1:0]];
  assign head_delay = mem_delay[rd_ptr[AW-1:0]];
  assign ra1        = head_inst[25:21];
  assign ra2        = head_inst[20:16];

  // Scan oldest to youngest so the lowest-index (youngest) match overrides.
  always_comb begin
    val1 = rd1;
    val2 = rd2;
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_wreg[k] && (fwd_wa[5*k +: 5] == ra1) && (ra1 != 5'd0)) begin
        val1 = fwd_wd[32*k +: 32];
        ld1  = fwd_mreg[k];
      end
      if (fwd_wreg[k] && (fwd_wa[5*k +: 5] == ra2) && (ra2 != 5'd0)) begin
        val2 = fwd_wd[32*k +: 32];
        ld2  = fwd_mreg[k];
      end
    end
  end

  assign src1     = (head_rreg1 && (ra1 != 5'd0)) ? val1 : 32'h0;
  assign src2     = (head_rreg2 && (ra2 != 5'd0)) ? val2 : 32'h0;
  assign stall_ld = ~empty & ((head_rreg1 & ld1) | (head_rreg2 & ld2));
  assign fire     = ~empty & ~stall_ld & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (fire) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty pointers mask stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr[AW-1:0]]  <= in_swapped;
      mem_pc[wr_ptr[AW-1:0]]    <= in_pc;
      mem_delay[wr_ptr[AW-1:0]] <= in_delay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_pc    <= 32'h0;
      out_delay <= 1'b0;
      out_src1  <= 32'h0;
      out_src2  <= 32'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_inst  <= 32'h0;
      out_pc    <= 32'h0;
      out_delay <= 1'b0;
      out_src1  <= 32'h0;
      out_src2  <= 32'h0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_inst  <= head_inst;
      out_pc    <= head_pc;
      out_delay <= head_delay;
      out_src1  <= src1;
      out_src2  <= src2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= 32'h0;
      perf_issue <= 32'h0;
    end else begin
      if (stall_ld && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
      if (fire && (perf_issue != 32'hFFFF_FFFF))     perf_issue <= perf_issue + 32'd1;
    end
  end
`endif

endmodule
